stack_ptr_bank: RTL and testbench
=================================

# stack_ptr_bank

Parametrised bank of hardware stack pointers for the stack-machine datapath. It generalises the fixed main-stack (MSP) and return-stack (RSP) pointer registers to NUM_STACKS independent channels, each of configurable width and depth. Every channel has push, pop and load operations, full/empty status, and a per-channel fault state machine that traps overflow, underflow and out-of-range loads. It sits beside PC/IR/ValA/ValB in stage 5 and drives memory-port addresses.

## Interface
- WIDTH, 16: pointer/address width in bits.
- NUM_STACKS, 2: number of channels. Channel 0 is the main stack; channel 1 is the return stack.
- DEPTH, 64: entries per stack.
- BASE, 16'h0400: base address of channel 0. Channel k occupies [BASE+k·DEPTH, BASE+(k+1)·DEPTH).

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- Op  in  2·NUM_STACKS  per-channel opcode. Channel k uses bits [2k+1:2k].
- LoadVal  in  WIDTH·NUM_STACKS  per-channel load value, used by OP_LOAD.
- FaultClr  in  NUM_STACKS  per-channel fault clear, level-sampled.
- SPOut  out  WIDTH·NUM_STACKS  per-channel stack pointer; it addresses the next free slot.
- Empty  out  NUM_STACKS  SP == channel base.
- Full  out  NUM_STACKS  SP == channel base + DEPTH.
- Overflow  out  NUM_STACKS  sticky; set by a push while Full.
- Underflow  out  NUM_STACKS  sticky; set by a pop while Empty.
- RangeErr  out  NUM_STACKS  sticky; set by a load outside [base, base+DEPTH].
- Fault  out  NUM_STACKS  channel is in the FAULT state.

## Operation
- Opcodes:
  - OP_NOP=00: hold.
  - OP_PUSH=01: SP ← SP+1.
  - OP_POP=10: SP ← SP−1.
  - OP_LOAD=11: SP ← LoadVal.
- The stack grows upward. The caller writes memory at SP before a push and reads memory at SP−1 on a pop.
- Each channel has a state machine with two states, RUN and FAULT.
- In RUN:
  - PUSH while Full: SP is unchanged, Overflow is set, go to FAULT.
  - POP while Empty: SP is unchanged, Underflow is set, go to FAULT.
  - LOAD with LoadVal < base or LoadVal > base+DEPTH: SP is unchanged, RangeErr is set, go to FAULT. LoadVal == base+DEPTH is legal and makes the channel Full.
  - Any other operation updates SP and stays in RUN.
- In FAULT:
  - All opcodes are ignored and SP holds.
  - FaultClr=1 clears Overflow, Underflow and RangeErr and returns to RUN.
- FaultClr while in RUN: clears all sticky flags; the same-cycle Op still executes.
- FaultClr and Op in the same cycle while in FAULT: the clear wins and Op is dropped.
- Channels are fully independent. Simultaneous operations on different channels all execute in the same cycle.
- Arithmetic is modulo 2^WIDTH. The bounds checks guarantee SP never wraps.
- Elaboration must fail if BASE + NUM_STACKS·DEPTH > 2^WIDTH or if DEPTH == 0.

## Timing
- Op, LoadVal and FaultClr are sampled on the rising CLK edge. The SP and flag updates are visible after that edge, so latency is one cycle.
- All outputs come from registers: Empty and Full are decoded from the registered SP only, with no input-to-output combinational path.
- Reset values (RST_N low, asynchronous):
  - SPOut[k] = BASE + k·DEPTH.
  - Empty = all ones, Full = 0.
  - Overflow, Underflow, RangeErr and Fault = 0.
  - State = RUN.
- Reset asserted mid-sequence returns every channel to these values immediately. No operation is lost or replayed after reset release.
- Reset release is synchronous to CLK: the first operation is sampled at the first rising edge with RST_N high.

## Structure
- Shared package stack_pkg:
  - Opcode constants OP_NOP, OP_PUSH, OP_POP, OP_LOAD.
  - Channel state enum ST_RUN, ST_FAULT.
- Sub-module stack_ptr_chan:
  - One channel, holding the SP register, state register, sticky flags and bounds compare.
  - Takes parameters WIDTH, DEPTH and CHAN_BASE.
- The top level instantiates stack_ptr_chan NUM_STACKS times through a generate loop with CHAN_BASE = BASE + k·DEPTH, and handles the port packing.

## Test plan
- Reset, then NOP on every channel: SPOut0 = 0x0400, SPOut1 = 0x0440, Empty = 2'b11, all flags 0.
- 64 pushes on channel 0: SPOut0 = 0x0440 and Full[0] = 1. The 65th push sets Overflow[0] and Fault[0] and SP stays 0x0440. A further pop is ignored. FaultClr → RUN, and the next pop gives 0x043F.
- Pop on an empty channel 1: Underflow[1] = 1 and SPOut1 = 0x0440. Channel 0 pushes in the same cycles still advance normally.
- Loads on channel 1:
  - LOAD 0x0480 is accepted and sets Full[1].
  - LOAD 0x0481 sets RangeErr[1] and SP stays 0x0480.
  - LOAD 0x043F on channel 1 sets RangeErr[1].
- Channel 0 in FAULT, FaultClr and PUSH asserted in the same cycle: flags clear and SP is unchanged. A push on the next cycle then increments SP by 1.
- Assert RST_N low mid-way through a push burst between clock edges: outputs return to their reset values before the next edge. After release, 3 pushes give SPOut0 = 0x0403.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared opcodes and channel state encoding
// for the stack pointer bank.
package stack_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } chanState_t;

endpackage

// File: rtl/stack_ptr_chan.sv
// One stack pointer channel: SP register, run/fault
// state, sticky error flags and bounds compare.
module stack_ptr_chan
    import stack_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 64,
    parameter logic [WIDTH-1:0] CHAN_BASE = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             faultClr,
    output logic [WIDTH-1:0] sp,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             rangeErr,
    output logic             fault
);

    // Bounds held one bit wider so base+DEPTH never wraps.
    localparam logic [WIDTH:0] LO = {1'b0, CHAN_BASE};
    localparam logic [WIDTH:0] HI = LO + (WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0] spReg;
    chanState_t       state;
    logic             ovfReg;
    logic             udfReg;
    logic             rngReg;
    logic             isEmpty;
    logic             isFull;
    logic             loadBad;
    logic [WIDTH:0]   ldExt;

    // Status decoded from the registered SP only.
    always_comb begin
        ldExt   = {1'b0, loadVal};
        isEmpty = (spReg == CHAN_BASE);
        isFull  = ({1'b0, spReg} == HI);
        loadBad = (ldExt < LO) || (ldExt > HI);
    end

    // SP update, bounds trapping and fault recovery.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            spReg  <= CHAN_BASE;
            state  <= ST_RUN;
            ovfReg <= 1'b0;
            udfReg <= 1'b0;
            rngReg <= 1'b0;
        end else if (state == ST_FAULT) begin
            if (faultClr) begin
                ovfReg <= 1'b0;
                udfReg <= 1'b0;
                rngReg <= 1'b0;
                state  <= ST_RUN;
            end
        end else begin
            if (faultClr) begin
                ovfReg <= 1'b0;
                udfReg <= 1'b0;
                rngReg <= 1'b0;
            end
            unique case (op)
                OP_NOP: begin
                end
                OP_PUSH: begin
                    if (isFull) begin
                        ovfReg <= 1'b1;
                        state  <= ST_FAULT;
                    end else begin
                        spReg <= spReg + WIDTH'(1);
                    end
                end
                OP_POP: begin
                    if (isEmpty) begin
                        udfReg <= 1'b1;
                        state  <= ST_FAULT;
                    end else begin
                        spReg <= spReg - WIDTH'(1);
                    end
                end
                OP_LOAD: begin
                    if (loadBad) begin
                        rngReg <= 1'b1;
                        state  <= ST_FAULT;
                    end else begin
                        spReg <= loadVal;
                    end
                end
            endcase
        end
    end

    assign sp        = spReg;
    assign empty     = isEmpty;
    assign full      = isFull;
    assign overflow  = ovfReg;
    assign underflow = udfReg;
    assign rangeErr  = rngReg;
    assign fault     = (state == ST_FAULT);

endmodule

// File: rtl/stack_ptr_bank.sv
// Bank of independent hardware stack pointers;
// channel 0 is the main stack, channel 1 the return stack.
module stack_ptr_bank
    import stack_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               NUM_STACKS = 2,
    parameter int               DEPTH      = 64,
    parameter logic [WIDTH-1:0] BASE       = 16'h0400
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [2*NUM_STACKS-1:0]       Op,
    input  logic [WIDTH*NUM_STACKS-1:0]   LoadVal,
    input  logic [NUM_STACKS-1:0]         FaultClr,
    output logic [WIDTH*NUM_STACKS-1:0]   SPOut,
    output logic [NUM_STACKS-1:0]         Empty,
    output logic [NUM_STACKS-1:0]         Full,
    output logic [NUM_STACKS-1:0]         Overflow,
    output logic [NUM_STACKS-1:0]         Underflow,
    output logic [NUM_STACKS-1:0]         RangeErr,
    output logic [NUM_STACKS-1:0]         Fault
);

    localparam longint unsigned SPAN =
        longint'(BASE) + longint'(NUM_STACKS) * longint'(DEPTH);
    localparam longint unsigned LIMIT = 64'd1 << WIDTH;

    // Reject parameter sets whose channels would leave the address space.
    if (DEPTH == 0) begin : gBadDepth
        $error("stack_ptr_bank: DEPTH must be non-zero");
    end
    if (SPAN > LIMIT) begin : gBadSpan
        $error("stack_ptr_bank: channels exceed address space");
    end

    for (genvar k = 0; k < NUM_STACKS; k++) begin : gChan
        localparam logic [WIDTH-1:0] CB =
            WIDTH'(longint'(BASE) + longint'(k) * longint'(DEPTH));

        stack_ptr_chan #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .CHAN_BASE(CB)
        ) uChan (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .op       (Op[2*k +: 2]),
            .loadVal  (LoadVal[WIDTH*k +: WIDTH]),
            .faultClr (FaultClr[k]),
            .sp       (SPOut[WIDTH*k +: WIDTH]),
            .empty    (Empty[k]),
            .full     (Full[k]),
            .overflow (Overflow[k]),
            .underflow(Underflow[k]),
            .rangeErr (RangeErr[k]),
            .fault    (Fault[k])
        );
    end

endmodule

// File: tb/tb_stack_ptr_bank.sv
// Self-checking bench for stack_ptr_bank: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_stack_ptr_bank;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [3:0]  Op = '0;
    logic [31:0] LoadVal = '0;
    logic [1:0]  FaultClr = '0;
    logic [31:0] SPOut;
    logic [1:0]  Empty, Full, Overflow, Underflow, RangeErr, Fault;

    int passCnt = 0;
    int totalCnt = 0;

    int mSp[2];
    bit mOvf[2], mUdf[2], mRng[2], mFlt[2];

    stack_ptr_bank dut (
        .CLK(CLK), .RST_N(RST_N), .Op(Op), .LoadVal(LoadVal),
        .FaultClr(FaultClr), .SPOut(SPOut), .Empty(Empty),
        .Full(Full), .Overflow(Overflow), .Underflow(Underflow),
        .RangeErr(RangeErr), .Fault(Fault)
    );

    always #5 CLK = ~CLK;

    function automatic int baseOf(int k);
        return 1024 + 64 * k;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mSp[k] = baseOf(k);
            mOvf[k] = 0; mUdf[k] = 0; mRng[k] = 0; mFlt[k] = 0;
        end
    endtask

    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            int o, lv, b;
            bit c;
            o = int'(Op[2*k +: 2]);
            lv = int'(LoadVal[16*k +: 16]);
            c = FaultClr[k];
            b = baseOf(k);
            if (mFlt[k]) begin
                if (c) begin
                    mOvf[k] = 0; mUdf[k] = 0; mRng[k] = 0; mFlt[k] = 0;
                end
            end else begin
                if (c) begin
                    mOvf[k] = 0; mUdf[k] = 0; mRng[k] = 0;
                end
                case (o)
                    1: if (mSp[k] == b + 64) begin
                           mOvf[k] = 1; mFlt[k] = 1;
                       end else mSp[k] = mSp[k] + 1;
                    2: if (mSp[k] == b) begin
                           mUdf[k] = 1; mFlt[k] = 1;
                       end else mSp[k] = mSp[k] - 1;
                    3: if (lv < b || lv > b + 64) begin
                           mRng[k] = 1; mFlt[k] = 1;
                       end else mSp[k] = lv;
                    default: ;
                endcase
            end
        end
    endtask

    // Apply inputs, clock once, advance the model, sample on negedge.
    task automatic step(input logic [1:0] o0, input logic [1:0] o1,
                        input logic [15:0] l0, input logic [15:0] l1,
                        input logic [1:0] clr);
        Op = {o1, o0};
        LoadVal = {l1, l0};
        FaultClr = clr;
        @(posedge CLK);
        modelStep();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        #1 RST_N = 1'b0;
        modelReset();
        @(negedge CLK);
        totalCnt++;
        if (SPOut !== 32'h0440_0400) $display("FAIL reset_sp got=%h want=%h", SPOut, 32'h0440_0400);
        else passCnt++;
        totalCnt++;
        if ({Empty, Full} !== 4'b1100) $display("FAIL reset_status got=%b want=1100", {Empty, Full});
        else passCnt++;
        totalCnt++;
        if ({Overflow, Underflow, RangeErr, Fault} !== 8'h00)
            $display("FAIL reset_flags got=%h want=00", {Overflow, Underflow, RangeErr, Fault});
        else passCnt++;
        RST_N = 1'b1;
        step(2'b00, 2'b00, 16'h0, 16'h0, 2'b00);
        totalCnt++;
        if (SPOut !== 32'h0440_0400 || Empty !== 2'b11)
            $display("FAIL nop_after_reset got=%h/%b want=04400400/11", SPOut, Empty);
        else passCnt++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 64; i++) step(2'b01, 2'b00, 16'h0, 16'h0, 2'b00);
        totalCnt++;
        if (SPOut[15:0] !== 16'h0440 || Full[0] !== 1'b1 || Fault[0] !== 1'b0)
            $display("FAIL push64 got sp=%h full=%b fault=%b want 0440/1/0", SPOut[15:0], Full[0], Fault[0]);
        else passCnt++;
        step(2'b01, 2'b00, 16'h0, 16'h0, 2'b00);
        totalCnt++;
        if (SPOut[15:0] !== 16'h0440 || Overflow[0] !== 1'b1 || Fault[0] !== 1'b1)
            $display("FAIL push65 got sp=%h ovf=%b fault=%b want 0440/1/1", SPOut[15:0], Overflow[0], Fault[0]);
        else passCnt++;
        step(2'b10, 2'b00, 16'h0, 16'h0, 2'b00);
        totalCnt++;
        if (SPOut[15:0] !== 16'h0440 || Fault[0] !== 1'b1)
            $display("FAIL pop_in_fault got sp=%h fault=%b want 0440/1", SPOut[15:0], Fault[0]);
        else passCnt++;
        step(2'b00, 2'b00, 16'h0, 16'h0, 2'b01);
        totalCnt++;
        if (Fault[0] !== 1'b0 || Overflow[0] !== 1'b0)
            $display("FAIL clr_ovf got fault=%b ovf=%b want 0/0", Fault[0], Overflow[0]);
        else passCnt++;
        step(2'b10, 2'b00, 16'h0, 16'h0, 2'b00);
        totalCnt++;
        if (SPOut[15:0] !== 16'h043F)
            $display("FAIL pop_after_clr got=%h want=043f", SPOut[15:0]);
        else passCnt++;
    endtask

    task automatic test_underflow();
        step(2'b01, 2'b10, 16'h0, 16'h0, 2'b00);
        totalCnt++;
        if (Underflow[1] !== 1'b1 || Fault[1] !== 1'b1 || SPOut[31:16] !== 16'h0440)
            $display("FAIL underflow1 got udf=%b fault=%b sp=%h want 1/1/0440", Underflow[1], Fault[1], SPOut[31:16]);
        else passCnt++;
        totalCnt++;
        if (SPOut[15:0] !== 16'h0440 || Fault[0] !== 1'b0)
            $display("FAIL chan0_indep got sp=%h fault=%b want 0440/0", SPOut[15:0], Fault[0]);
        else passCnt++;
        step(2'b00, 2'b00, 16'h0, 16'h0, 2'b10);
        totalCnt++;
        if (Underflow[1] !== 1'b0 || Fault[1] !== 1'b0)
            $display("FAIL clr_udf got udf=%b fault=%b want 0/0", Underflow[1], Fault[1]);
        else passCnt++;
    endtask

    task automatic test_load();
        step(2'b00, 2'b11, 16'h0, 16'h0480, 2'b00);
        totalCnt++;
        if (SPOut[31:16] !== 16'h0480 || Full[1] !== 1'b1 || RangeErr[1] !== 1'b0)
            $display("FAIL load_top got sp=%h full=%b rng=%b want 0480/1/0", SPOut[31:16], Full[1], RangeErr[1]);
        else passCnt++;
        step(2'b00, 2'b11, 16'h0, 16'h0481, 2'b00);
        totalCnt++;
        if (SPOut[31:16] !== 16'h0480 || RangeErr[1] !== 1'b1 || Fault[1] !== 1'b1)
            $display("FAIL load_high got sp=%h rng=%b fault=%b want 0480/1/1", SPOut[31:16], RangeErr[1], Fault[1]);
        else passCnt++;
        step(2'b00, 2'b00, 16'h0, 16'h0, 2'b10);
        step(2'b00, 2'b11, 16'h0, 16'h043F, 2'b00);
        totalCnt++;
        if (SPOut[31:16] !== 16'h0480 || RangeErr[1] !== 1'b1)
            $display("FAIL load_low got sp=%h rng=%b want 0480/1", SPOut[31:16], RangeErr[1]);
        else passCnt++;
        step(2'b00, 2'b00, 16'h0, 16'h0, 2'b10);
    endtask

    task automatic test_clr_push();
        step(2'b11, 2'b00, 16'h0410, 16'h0, 2'b00);
        step(2'b11, 2'b00, 16'h0300, 16'h0, 2'b00);
        totalCnt++;
        if (Fault[0] !== 1'b1 || RangeErr[0] !== 1'b1 || SPOut[15:0] !== 16'h0410)
            $display("FAIL enter_fault got fault=%b rng=%b sp=%h want 1/1/0410", Fault[0], RangeErr[0], SPOut[15:0]);
        else passCnt++;
        step(2'b01, 2'b00, 16'h0, 16'h0, 2'b01);
        totalCnt++;
        if (Fault[0] !== 1'b0 || RangeErr[0] !== 1'b0 || SPOut[15:0] !== 16'h0410)
            $display("FAIL clr_wins got fault=%b rng=%b sp=%h want 0/0/0410", Fault[0], RangeErr[0], SPOut[15:0]);
        else passCnt++;
        step(2'b01, 2'b00, 16'h0, 16'h0, 2'b00);
        totalCnt++;
        if (SPOut[15:0] !== 16'h0411)
            $display("FAIL push_after_clr got=%h want=0411", SPOut[15:0]);
        else passCnt++;
    endtask

    task automatic test_reset_mid();
        step(2'b01, 2'b01, 16'h0, 16'h0, 2'b00);
        step(2'b01, 2'b01, 16'h0, 16'h0, 2'b00);
        @(posedge CLK);
        modelStep();
        #2 RST_N = 1'b0;
        modelReset();
        #1;
        totalCnt++;
        if (SPOut !== 32'h0440_0400 || Empty !== 2'b11 || Full !== 2'b00 || Fault !== 2'b00)
            $display("FAIL async_reset got sp=%h e=%b f=%b flt=%b want 04400400/11/00/00", SPOut, Empty, Full, Fault);
        else passCnt++;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) step(2'b01, 2'b00, 16'h0, 16'h0, 2'b00);
        totalCnt++;
        if (SPOut !== 32'h0440_0403)
            $display("FAIL push3_after_reset got=%h want=04400403", SPOut);
        else passCnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [1:0] o0, o1, clr;
            logic [15:0] l0, l1;
            logic [43:0] got, exp;
            o0 = 2'($urandom_range(0, 3));
            o1 = 2'($urandom_range(0, 3));
            l0 = 16'($urandom_range(baseOf(0) - 3, baseOf(0) + 67));
            l1 = 16'($urandom_range(baseOf(1) - 3, baseOf(1) + 67));
            clr[0] = ($urandom_range(0, 5) == 0);
            clr[1] = ($urandom_range(0, 5) == 0);
            step(o0, o1, l0, l1, clr);
            got = {SPOut, Empty, Full, Overflow, Underflow, RangeErr, Fault};
            exp = {16'(mSp[1]), 16'(mSp[0]),
                   mSp[1] == baseOf(1), mSp[0] == baseOf(0),
                   mSp[1] == baseOf(1) + 64, mSp[0] == baseOf(0) + 64,
                   mOvf[1], mOvf[0], mUdf[1], mUdf[0],
                   mRng[1], mRng[0], mFlt[1], mFlt[0]};
            totalCnt++;
            if (got !== exp) $display("FAIL random cycle %0d got=%h want=%h", n, got, exp);
            else passCnt++;
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_underflow();
        test_load();
        test_clr_push();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
